// File: rtl/ep_operand_engine.sv
// ep_operand_engine
//
// Operand engine between host wire-in and wire-out endpoints. A rising edge
// on ctrl[0] captures operands A and B, registers their sum and carry on the
// next cycle, and runs a serial shift-add multiplier that produces the
// unsigned 2*WIDTH-bit product after WIDTH iterations.
//
// Ports:
//   ti_clk     host interface clock, rising edge
//   rst_n      asynchronous active-low reset
//   op_a/op_b  operand wire-ins, sampled only on an accepted start
//   ctrl       bit0 start level, bit1 soft clear (level), others ignored
//   sum        low WIDTH bits of A+B
//   sum_carry  carry-out of A+B
//   prod_lo    product bits [WIDTH-1:0]
//   prod_hi    product bits [2*WIDTH-1:WIDTH]
//   status     {.., rejected-start count @ [8 +: CNT_W], 5'b0, carry, done, busy}
//   busy       multiply in progress
//   done       results valid until next accepted start or clear

module ep_operand_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             ti_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] ctrl,
  output logic [WIDTH-1:0] sum,
  output logic             sum_carry,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] status,
  output logic             busy,
  output logic             done
);

  localparam int BC_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Control state
  logic [1:0]       state;
  logic             start_q;
  logic             armed;
  logic [CNT_W-1:0] rej_cnt;
  logic [BC_W-1:0]  bit_cnt;

  // Multiplier datapath (not reset; only observed through prod on DONE entry)
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  logic               start_lvl;
  logic               clr;
  logic               start_evt;
  logic               accept;
  logic               reject;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH:0]   shift_in;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               unused_ctrl;

  assign start_lvl   = ctrl[0];
  assign clr         = ctrl[1];
  assign unused_ctrl = ^ctrl[WIDTH-1:2];

  // armed stays low after reset until ctrl[0] has been seen low, so a level
  // held through reset release cannot masquerade as a fresh rising edge.
  assign start_evt = start_lvl & ~start_q & armed;
  assign accept    = start_evt & ~clr & (state != ST_MUL);
  assign reject    = start_evt & ~clr & (state == ST_MUL);

  assign sum_ext = {1'b0, op_a} + {1'b0, op_b};

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift {carry, acc} right so the carry lands in the MSB.
  assign add_hi   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  assign shift_in = {add_hi, acc[WIDTH-1:0]};
  assign acc_nxt  = shift_in[2*WIDTH:1];

  assign busy = (state == ST_MUL);
  assign done = (state == ST_DONE);

  always_comb begin
    status             = '0;
    status[0]          = busy;
    status[1]          = done;
    status[2]          = sum_carry;
    status[8 +: CNT_W] = rej_cnt;
  end

  // Control and visible result registers
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      armed     <= 1'b0;
      rej_cnt   <= '0;
      bit_cnt   <= '0;
      sum       <= '0;
      sum_carry <= 1'b0;
      prod_lo   <= '0;
      prod_hi   <= '0;
    end else begin
      start_q <= start_lvl;
      if (!start_lvl) begin
        armed <= 1'b1;
      end

      if (clr) begin
        state     <= ST_IDLE;
        rej_cnt   <= '0;
        bit_cnt   <= '0;
        sum       <= '0;
        sum_carry <= 1'b0;
        prod_lo   <= '0;
        prod_hi   <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (accept) begin
              state     <= ST_MUL;
              bit_cnt   <= BC_W'(WIDTH);
              sum       <= sum_ext[WIDTH-1:0];
              sum_carry <= sum_ext[WIDTH];
            end
          end
          ST_MUL: begin
            if (reject) begin
              rej_cnt <= sat_inc(rej_cnt);
            end
            bit_cnt <= bit_cnt - BC_W'(1);
            // Final iteration: publish the completed product in one step.
            if (bit_cnt == BC_W'(1)) begin
              state   <= ST_DONE;
              prod_lo <= acc_nxt[WIDTH-1:0];
              prod_hi <= acc_nxt[2*WIDTH-1:WIDTH];
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Multiplier datapath registers
  always_ff @(posedge ti_clk) begin
    if (accept) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
    end else if (state == ST_MUL) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: tb/tb_ep_operand_engine.sv
// Testbench for ep_operand_engine: directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.

module tb_ep_operand_engine;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             ti_clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] ctrl;
  logic [WIDTH-1:0] sum;
  logic             sum_carry;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] status;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;
  int rej_model = 0;

  always #5 ti_clk = ~ti_clk;

  ep_operand_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .ti_clk   (ti_clk),
    .rst_n    (rst_n),
    .op_a     (op_a),
    .op_b     (op_b),
    .ctrl     (ctrl),
    .sum      (sum),
    .sum_carry(sum_carry),
    .prod_lo  (prod_lo),
    .prod_hi  (prod_hi),
    .status   (status),
    .busy     (busy),
    .done     (done)
  );

  // Reference model: plain unsigned arithmetic
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctrl  = '0;
    op_a  = $urandom;
    op_b  = $urandom;
    #2;
    checks++;
    if ({sum, sum_carry, prod_lo, prod_hi, status, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: sum=%h c=%b prod=%h_%h status=%h busy=%b done=%b, required all 0",
               sum, sum_carry, prod_hi, prod_lo, status, busy, done);
    end
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({sum, sum_carry, prod_lo, prod_hi, status, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_release_idle: status=%h busy=%b done=%b, required 0", status, busy, done);
    end
    rej_model = 0;
  endtask

  task automatic test_basic();
    op_a = 32'd5;
    op_b = 32'd7;
    ctrl = 32'd1;
    tick();
    checks++;
    if (sum !== 32'd12 || sum_carry !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum: sum=%0d c=%b, required 12 c=0", sum, sum_carry);
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    ctrl = '0;
    repeat (31) tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency_early: done=%b busy=%b at cycle 32, required done=0 busy=1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: done=%b busy=%b at cycle 33, required done=1 busy=0", done, busy);
    end
    checks++;
    if (prod_lo !== 32'd35 || prod_hi !== 32'd0 || status !== 32'h2) begin
      failures++;
      $display("FAIL basic_result: prod=%h_%h status=%h, required 0_23 status=2", prod_hi, prod_lo, status);
    end
  endtask

  task automatic test_extremes();
    int n;
    op_a = 32'hFFFF_FFFF;
    op_b = 32'hFFFF_FFFF;
    ctrl = 32'd1;
    tick();
    checks++;
    if (sum !== 32'hFFFF_FFFE || sum_carry !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL ext_sum: sum=%h c=%b done=%b, required fffffffe c=1 done=0", sum, sum_carry, done);
    end
    ctrl = '0;
    wait_done(40, n);
    checks++;
    if (done !== 1'b1 || n != 32) begin
      failures++;
      $display("FAIL ext_latency: done=%b after %0d cycles, required done=1 after 32", done, n);
    end
    checks++;
    if (prod_hi !== 32'hFFFF_FFFE || prod_lo !== 32'h0000_0001 || status !== 32'h6) begin
      failures++;
      $display("FAIL ext_prod: prod=%h_%h status=%h, required fffffffe_00000001 status=6",
               prod_hi, prod_lo, status);
    end
  endtask

  task automatic test_busy_reject();
    int n;
    op_a = 32'd3;
    op_b = 32'd4;
    ctrl = 32'd1;
    tick();
    ctrl = '0;
    tick();
    tick();
    op_a = 32'd9;
    op_b = 32'd9;
    ctrl = 32'd1;
    tick();
    ctrl = '0;
    tick();
    ctrl = 32'd1;
    tick();
    ctrl = '0;
    rej_model += 2;
    wait_done(40, n);
    checks++;
    if (done !== 1'b1 || {prod_hi, prod_lo} !== 64'd12 || sum !== 32'd7) begin
      failures++;
      $display("FAIL reject_result: done=%b prod=%h_%h sum=%0d, required done=1 prod=12 sum=7",
               done, prod_hi, prod_lo, sum);
    end
    checks++;
    if (status[15:8] !== 8'(rej_model)) begin
      failures++;
      $display("FAIL reject_count: count=%0d, required %0d", status[15:8], rej_model);
    end
  endtask

  task automatic test_level_hold();
    int n;
    int rises;
    logic prev_busy;
    ctrl = 32'd2;
    tick();
    rej_model = 0;
    checks++;
    if ({sum, sum_carry, prod_lo, prod_hi, status, busy, done} !== '0) begin
      failures++;
      $display("FAIL clear_outputs: sum=%h prod=%h_%h status=%h, required all 0", sum, prod_hi, prod_lo, status);
    end
    ctrl = '0;
    tick();
    op_a = 32'd2;
    op_b = 32'd3;
    ctrl = 32'd1;
    rises = 0;
    prev_busy = busy;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    checks++;
    if (rises != 1) begin
      failures++;
      $display("FAIL hold_single_op: busy rose %0d times, required 1", rises);
    end
    checks++;
    if (done !== 1'b1 || {prod_hi, prod_lo} !== 64'd6 || status[15:8] !== 8'd0) begin
      failures++;
      $display("FAIL hold_result: done=%b prod=%h_%h count=%0d, required done=1 prod=6 count=0",
               done, prod_hi, prod_lo, status[15:8]);
    end
    ctrl = '0;
    tick();
    op_a = 32'd10;
    ctrl = 32'd1;
    tick();
    ctrl = '0;
    wait_done(40, n);
    checks++;
    if (done !== 1'b1 || {prod_hi, prod_lo} !== 64'd30) begin
      failures++;
      $display("FAIL hold_retrigger: done=%b prod=%h_%h, required done=1 prod=30", done, prod_hi, prod_lo);
    end
  endtask

  task automatic test_clear_vs_start();
    int n;
    bit saw_busy;
    op_a = 32'd6;
    op_b = 32'd7;
    ctrl = 32'd3;
    tick();
    rej_model = 0;
    checks++;
    if ({sum, sum_carry, prod_lo, prod_hi, status, busy, done} !== '0) begin
      failures++;
      $display("FAIL clear_wins: sum=%h prod=%h_%h status=%h busy=%b, required all 0",
               sum, prod_hi, prod_lo, status, busy);
    end
    ctrl = '0;
    saw_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL clear_drops_start: busy_seen=%b done=%b, required 0 0", saw_busy, done);
    end
    ctrl = 32'd1;
    tick();
    ctrl = '0;
    wait_done(40, n);
    checks++;
    if ({prod_hi, prod_lo} !== 64'd42) begin
      failures++;
      $display("FAIL clear_setup_prod: prod=%h_%h, required 42", prod_hi, prod_lo);
    end
    op_a = 32'd100;
    op_b = 32'd200;
    ctrl = 32'd1;
    tick();
    ctrl = '0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1 || {prod_hi, prod_lo} !== 64'd42) begin
      failures++;
      $display("FAIL mid_mul_hold: busy=%b prod=%h_%h, required busy=1 prod=42", busy, prod_hi, prod_lo);
    end
    ctrl = 32'd2;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {prod_hi, prod_lo} !== 64'd0 || sum !== 32'd0) begin
      failures++;
      $display("FAIL abort_clear: busy=%b done=%b prod=%h_%h sum=%h, required all 0",
               busy, done, prod_hi, prod_lo, sum);
    end
    ctrl = '0;
    tick();
  endtask

  // Randomized operations; while busy, ctrl[0] is wiggled (randomly or in an
  // alternating pattern) and operands/ignored ctrl bits are scrambled.
  task automatic test_random_ops(input int nops, input bit alternate);
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] s;
    logic [63:0] p;
    logic        prev;
    logic        lvl;
    logic [31:0] exp_status;
    for (int k = 0; k < nops; k++) begin
      a = $urandom;
      b = $urandom;
      if (k % 4 == 0) b = a;
      s = ref_sum(a, b);
      p = ref_prod(a, b);
      op_a = a;
      op_b = b;
      ctrl = ($urandom & 32'hFFFF_FFFC) | 32'd1;
      tick();
      checks++;
      if ({sum_carry, sum} !== s) begin
        failures++;
        $display("FAIL rand_sum[%0d]: got %h, required %h", k, {sum_carry, sum}, s);
      end
      prev = 1'b1;
      for (int i = 1; i <= 30; i++) begin
        lvl = alternate ? 1'(i % 2) : 1'($urandom_range(0, 1));
        ctrl = ($urandom & 32'hFFFF_FFFC) | {31'd0, lvl};
        op_a = $urandom;
        op_b = $urandom;
        tick();
        if (lvl && !prev) rej_model = (rej_model < 255) ? rej_model + 1 : 255;
        prev = lvl;
      end
      ctrl = $urandom & 32'hFFFF_FFFC;
      tick();
      tick();
      exp_status = (32'(rej_model) << 8) | {29'd0, s[32], 2'b10};
      checks++;
      if (done !== 1'b1 || {prod_hi, prod_lo} !== p) begin
        failures++;
        $display("FAIL rand_prod[%0d]: done=%b prod=%h_%h, required done=1 prod=%h",
                 k, done, prod_hi, prod_lo, p);
      end
      checks++;
      if (status !== exp_status) begin
        failures++;
        $display("FAIL rand_status[%0d]: status=%h, required %h", k, status, exp_status);
      end
    end
  endtask

  task automatic test_saturation();
    ctrl = 32'd2;
    tick();
    ctrl = '0;
    tick();
    rej_model = 0;
    test_random_ops(20, 1'b1);
    checks++;
    if (status[15:8] !== 8'hFF) begin
      failures++;
      $display("FAIL sat_count: count=%0d, required 255", status[15:8]);
    end
  endtask

  task automatic test_async_reset();
    int n;
    op_a = 32'd11;
    op_b = 32'd13;
    ctrl = 32'd1;
    tick();
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    rej_model = 0;
    checks++;
    if ({sum, sum_carry, prod_lo, prod_hi, status, busy, done} !== '0) begin
      failures++;
      $display("FAIL async_reset: sum=%h prod=%h_%h status=%h busy=%b, required all 0",
               sum, prod_hi, prod_lo, status, busy);
    end
    tick();
    tick();
    #2 rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 32'd0) begin
      failures++;
      $display("FAIL reset_held_start: busy=%b done=%b sum=%h, required 0 0 0", busy, done, sum);
    end
    ctrl = '0;
    tick();
    ctrl = 32'd1;
    tick();
    checks++;
    if (busy !== 1'b1 || sum !== 32'd24) begin
      failures++;
      $display("FAIL reset_retoggle: busy=%b sum=%0d, required busy=1 sum=24", busy, sum);
    end
    ctrl = '0;
    wait_done(40, n);
    checks++;
    if (done !== 1'b1 || {prod_hi, prod_lo} !== 64'd143) begin
      failures++;
      $display("FAIL reset_retoggle_prod: done=%b prod=%h_%h, required done=1 prod=143",
               done, prod_hi, prod_lo);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_busy_reject();
    test_level_hold();
    test_clear_vs_start();
    test_random_ops(20, 1'b0);
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ep_operand_engine.md
Name: ep_operand_engine

Overview:
- Sits directly downstream of the host wire-in endpoints (operand words A and B, plus a control word) and directly upstream of the wire-out endpoints that return results to the host.
- On a start request it captures both 32-bit operands and computes their sum in a single pass.
- It computes their unsigned 64-bit product with a serial shift-add multiplier.
- It exposes the results plus a status word for host readback. All logic runs in the host interface clock domain.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.
- CNT_W, 8, width of the rejected-start counter (saturating).

Ports:
- ti_clk  input  1  host interface clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_a  input  WIDTH  operand A from wire-in; sampled only on accepted start.
- op_b  input  WIDTH  operand B from wire-in; sampled only on accepted start.
- ctrl  input  WIDTH  control wire-in: bit0 = start level, bit1 = soft clear; other bits ignored.
- sum  output  WIDTH  low WIDTH bits of A+B.
- sum_carry  output  1  carry-out of A+B.
- prod_lo  output  WIDTH  product bits [WIDTH-1:0].
- prod_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- status  output  WIDTH  bit0 busy, bit1 done, bit2 sum_carry, bits[8+CNT_W-1:8] rejected-start count, rest 0.
- busy  output  1  multiply in progress.
- done  output  1  results valid, held until next accepted start or clear.

Behaviour:
- Start detection: ctrl[0] is registered once (start_q). A start event is ctrl[0]=1 with start_q=0 (rising edge). A held level produces exactly one event.
- States: IDLE, MUL, DONE.
- IDLE: on a start event:
  - capture op_a and op_b into operand registers;
  - compute sum and sum_carry from the captured values; they are registered and valid on the cycle after the start edge;
  - clear the product accumulator and load the bit counter with WIDTH;
  - set busy=1, done=0, and go to MUL.
- MUL: each cycle, when the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator with carry. Then shift the {carry, accumulator} right by 1, decrement the counter, and shift the multiplier right.
  - After exactly WIDTH cycles in MUL, go to DONE.
  - prod_lo and prod_hi update only on the transition into DONE; they are never exposed partially.
- Latency:
  - done rises exactly WIDTH+1 cycles after the cycle in which the start edge is registered (33 for the default).
  - sum is valid 1 cycle after the start edge.
- DONE: busy=0 and done=1. A start event behaves as in IDLE, re-entering MUL directly; done drops the cycle after the start edge.
- Start while busy: a start event in MUL is ignored; the operands are not re-sampled. The rejected-start counter increments and saturates at 2^CNT_W-1.
- Soft clear: ctrl[1]=1 is level-sensitive and synchronous.
  - Forces IDLE and zeroes sum, sum_carry, prod_lo, prod_hi, busy, done and the rejected-start counter.
  - Aborts an in-flight multiply.
  - When clear and a start event occur in the same cycle, clear wins and start is dropped (not counted).
- Reset: rst_n low asynchronously forces IDLE. All outputs are 0, start_q=0, and the counter is 0.
  - Reset mid-multiply aborts with no partial results visible.
  - A ctrl[0] held high through reset release does not produce a start until it goes low and high again.
- Arithmetic: unsigned throughout.
  - Sum wraps modulo 2^WIDTH, with the carry reported separately.
  - The product is exact over 2*WIDTH bits; no overflow is possible.
- Operand wires may change freely while busy without affecting the result.

Test Plan:
- Basic: A=5, B=7, pulse ctrl[0] -> sum=12 and sum_carry=0 after 1 cycle; done=1 after 33 cycles; prod_lo=35, prod_hi=0; status=0x2.
- Extremes: A=B=0xFFFFFFFF -> sum=0xFFFFFFFE, sum_carry=1; prod_hi=0xFFFFFFFE, prod_lo=0x00000001; status bit2=1.
- Busy rejection: start A=3, B=4; while busy change operands to 9,9 and toggle ctrl[0] twice -> product=12; status[15:8]=2.
- Level hold: hold ctrl[0]=1 for 100 cycles with A=2, B=3 -> exactly one operation, prod_lo=6, counter stays 0. Then drop and raise ctrl[0] with A=10 -> new product 30.
- Clear vs start: in DONE, assert ctrl[1] and a start edge in the same cycle -> all results 0, state IDLE, counter 0, busy never asserts. Abort mid-MUL via ctrl[1] -> busy=0, done=0 next cycle, prod=0.
- Async reset: drop rst_n at MUL cycle 10, off-clock-edge -> outputs 0 immediately. Release with ctrl[0] held high -> no start until ctrl[0] is re-toggled.
